// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI master controller.
// Holds the FSM state enum, default parameters and sizing helpers.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_CS_SETUP   = 1;
    localparam int DEF_CS_HOLD    = 1;

    // sclk toggles per transfer: two per bit
    function automatic int edge_count(input int dw);
        return 2 * dw;
    endfunction

    // counters hold their maximum value without wrapping
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    localparam int EDGE_CNT = edge_count(DEF_DATA_WIDTH);

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Bundle of the SPI master's word handshake and serial pins.
// master: the controller side; slave: the user/BFM side.
interface spi_master_ctrl_if
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  cs_n;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  tx_valid, tx_data, cpol, cpha, lsb_first, miso,
        output tx_ready, rx_valid, rx_data, busy, cs_n, sclk, mosi
    );

    modport slave (
        output tx_valid, tx_data, cpol, cpha, lsb_first, miso,
        input  tx_ready, rx_valid, rx_data, busy, cs_n, sclk, mosi
    );

endinterface

// File: rtl/spi_clk_gen.sv
// sclk edge strobe generator: one tick every CLK_DIV enabled cycles.
// Ports: clk, rst, en (clears when low), tick, lead (tick is a leading edge).
module spi_clk_gen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic lead
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);
    // odd toggles (phase still 0) are leading edges
    assign lead = ~phase;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: accepts one word per transfer, returns the received word.
// Ports: pclk, areset (sync, active-high), bus (word handshake + SPI pins).
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_SETUP   = DEF_CS_SETUP,
    parameter int CS_HOLD    = DEF_CS_HOLD
) (
    input  logic              pclk,
    input  logic              areset,
    spi_master_ctrl_if.master bus
);

    localparam int EDGES = edge_count(DATA_WIDTH);
    localparam int EW    = cnt_width(EDGES);
    localparam int WMAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int WW    = cnt_width(WMAX);

    localparam logic [EW-1:0] E_LAST = EW'(EDGES - 1);
    localparam logic [WW-1:0] S_LAST = WW'(CS_SETUP - 1);
    localparam logic [WW-1:0] H_LAST = WW'(CS_HOLD - 1);

    state_t                state;
    logic                  rdy;
    logic                  busy_q;
    logic                  cs_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  rx_pulse;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  lsb_q;
    logic [EW-1:0]         edge_cnt;
    logic [WW-1:0]         wait_cnt;

    logic xfer_en;
    logic tick;
    logic lead;
    logic accept;
    logic last_edge;
    logic shift_ev;
    logic sample_ev;

    function automatic logic head(
        input logic [DATA_WIDTH-1:0] w,
        input logic                  lsb
    );
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(
        input logic [DATA_WIDTH-1:0] w,
        input logic                  lsb
    );
        return lsb ? {1'b0, w[DATA_WIDTH-1:1]}
                   : {w[DATA_WIDTH-2:0], 1'b0};
    endfunction

    // received bits land in the same order they were sent
    function automatic logic [DATA_WIDTH-1:0] capture(
        input logic [DATA_WIDTH-1:0] w,
        input logic                  lsb,
        input logic                  b
    );
        return lsb ? {b, w[DATA_WIDTH-1:1]}
                   : {w[DATA_WIDTH-2:0], b};
    endfunction

    assign xfer_en = (state == XFER);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk (pclk),
        .rst (areset),
        .en  (xfer_en),
        .tick(tick),
        .lead(lead)
    );

    assign accept    = (state == IDLE) && rdy && bus.tx_valid;
    assign last_edge = tick && (edge_cnt == E_LAST);
    // cpha=0 presents bit 0 at accept, so the final trailing edge has nothing left
    assign shift_ev  = tick && (cpha_q ? lead : (!lead && !last_edge));
    assign sample_ev = tick && (cpha_q ? !lead : lead);

    always_ff @(posedge pclk) begin
        if (areset) begin
            state    <= IDLE;
            rdy      <= 1'b0;
            busy_q   <= 1'b0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            rx_pulse <= 1'b0;
            rx_q     <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            edge_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            rx_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    sclk_q <= bus.cpol;
                    if (accept) begin
                        state    <= SETUP;
                        rdy      <= 1'b0;
                        busy_q   <= 1'b1;
                        cs_q     <= 1'b0;
                        cpol_q   <= bus.cpol;
                        cpha_q   <= bus.cpha;
                        lsb_q    <= bus.lsb_first;
                        wait_cnt <= '0;
                        edge_cnt <= '0;
                        rx_sh    <= '0;
                        if (!bus.cpha) begin
                            mosi_q <= head(bus.tx_data, bus.lsb_first);
                            tx_sh  <= advance(bus.tx_data, bus.lsb_first);
                        end else begin
                            tx_sh <= bus.tx_data;
                        end
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                SETUP: begin
                    if (wait_cnt == S_LAST) begin
                        state    <= XFER;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                XFER: begin
                    if (tick) begin
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + EW'(1);
                    end
                    if (shift_ev) begin
                        mosi_q <= head(tx_sh, lsb_q);
                        tx_sh  <= advance(tx_sh, lsb_q);
                    end
                    if (sample_ev) begin
                        rx_sh <= capture(rx_sh, lsb_q, bus.miso);
                    end
                    if (last_edge) begin
                        state    <= HOLD;
                        wait_cnt <= '0;
                        edge_cnt <= '0;
                    end
                end
                HOLD: begin
                    sclk_q <= cpol_q;
                    if (wait_cnt == H_LAST) begin
                        state    <= IDLE;
                        cs_q     <= 1'b1;
                        busy_q   <= 1'b0;
                        rx_q     <= rx_sh;
                        rx_pulse <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ready is forced low while reset is held, even mid-IDLE
    assign bus.tx_ready = rdy && !areset;
    assign bus.busy     = busy_q;
    assign bus.cs_n     = cs_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.rx_valid = rx_pulse;
    assign bus.rx_data  = rx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: default 8-bit instance with a
// slave model or loopback, plus a 16-bit CLK_DIV=1 loopback instance.
module tb_spi_master_ctrl;
    import spi_master_pkg::*;

    logic pclk   = 1'b0;
    logic areset = 1'b1;
    always #5 pclk = ~pclk;

    spi_master_ctrl_if #(.DATA_WIDTH(8))  a ();
    spi_master_ctrl_if #(.DATA_WIDTH(16)) b ();

    spi_master_ctrl #(
        .DATA_WIDTH(8), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)
    ) dut_a (
        .pclk(pclk), .areset(areset), .bus(a)
    );

    spi_master_ctrl #(
        .DATA_WIDTH(16), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)
    ) dut_b (
        .pclk(pclk), .areset(areset), .bus(b)
    );

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic       aborted;
        logic [7:0] cap;
        logic       cpol;
    } xf_t;

    xf_t         xq_a[$];
    logic [7:0]  rq_a[$];
    logic [15:0] rq_b[$];
    int          nb_pend = 0;

    // slave model for instance a
    logic       a_loop   = 1'b1;
    logic       bfm_cpha = 1'b0;
    logic       bfm_lsb  = 1'b0;
    logic [7:0] bfm_ret  = 8'h00;
    logic       bfm_miso = 1'b0;
    int         bfm_idx  = 0;

    assign a.miso = a_loop ? a.mosi : bfm_miso;
    assign b.miso = b.mosi;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input int i, input logic [7:0] r,
                                    input logic lsb);
        if (i > 7) return 1'b0;
        return lsb ? r[i] : r[7-i];
    endfunction

    // monitor state for instance a
    logic a_pcs = 1'b1, a_psclk = 1'b0, a_pmosi = 1'b0, a_sclk0 = 1'b0;
    logic [7:0] a_cap = '0;
    int a_low, a_tog, a_gap, a_gmin, a_gmax, a_bad;
    int a_acc = 0, a_nx = 0, a_viol = 0, a_rxw = 0;
    logic a_lead, a_smp;
    xf_t  a_e;

    always @(negedge pclk) begin
        if (a.tx_valid && a.tx_ready && !areset) a_acc++;
        if (a.cs_n == 1'b0 && (a.tx_ready || !a.busy)) a_viol++;
        if (a.rx_valid === 1'b1) begin
            if (rq_a.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL a_rx_unexpected: got %0h, expected no word",
                         a.rx_data);
            end else begin
                chk("a_rx_data", a.rx_data, rq_a.pop_front());
            end
            a_rxw++;
        end else if (a_rxw != 0) begin
            chk("a_rx_pulse_width", a_rxw, 1);
            a_rxw = 0;
        end
        if (a.cs_n == 1'b0) begin
            if (a_pcs) begin
                a_low = 1; a_tog = 0; a_gap = 0;
                a_gmin = 999; a_gmax = 0; a_bad = 0;
                a_cap = '0; a_sclk0 = a.sclk;
                bfm_idx = 0;
                if (!bfm_cpha) bfm_miso = bit_of(0, bfm_ret, bfm_lsb);
            end else begin
                a_low++;
                a_gap++;
                if (a.sclk != a_psclk) begin
                    a_tog++;
                    if (a_tog > 1) begin
                        if (a_gap < a_gmin) a_gmin = a_gap;
                        if (a_gap > a_gmax) a_gmax = a_gap;
                    end
                    a_gap  = 0;
                    a_lead = (a_tog % 2) == 1;
                    a_smp  = bfm_cpha ? !a_lead : a_lead;
                    if (a_smp) begin
                        a_cap = {a_cap[6:0], a.mosi};
                        if (a.mosi != a_pmosi) a_bad++;
                    end else if (bfm_cpha) begin
                        bfm_miso = bit_of(bfm_idx, bfm_ret, bfm_lsb);
                        bfm_idx++;
                    end else begin
                        bfm_idx++;
                        bfm_miso = bit_of(bfm_idx, bfm_ret, bfm_lsb);
                    end
                end else if (a.mosi != a_pmosi) begin
                    a_bad++;
                end
            end
        end else if (!a_pcs) begin
            a_nx++;
            if (xq_a.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL a_cs_unexpected: got cs_n rise, expected none");
            end else begin
                a_e = xq_a.pop_front();
                if (!a_e.aborted) begin
                    chk("a_cs_low_cycles", a_low, 34);
                    chk("a_sclk_toggles", a_tog, 16);
                    chk("a_toggle_gap_min", a_gmin, 2);
                    chk("a_toggle_gap_max", a_gmax, 2);
                    chk("a_mosi_sequence", a_cap, a_e.cap);
                    chk("a_mosi_wrong_edge", a_bad, 0);
                    chk("a_sclk_at_cs_fall", a_sclk0, a_e.cpol);
                end
            end
        end
        a_pcs   = a.cs_n;
        a_psclk = a.sclk;
        a_pmosi = a.mosi;
    end

    // monitor state for instance b
    logic b_pcs = 1'b1, b_psclk = 1'b0;
    int b_low, b_tog, b_gap, b_gmin, b_gmax;

    always @(negedge pclk) begin
        if (b.rx_valid === 1'b1) begin
            if (rq_b.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL b_rx_unexpected: got %0h, expected no word",
                         b.rx_data);
            end else begin
                chk("b_rx_data", b.rx_data, rq_b.pop_front());
            end
        end
        if (b.cs_n == 1'b0) begin
            if (b_pcs) begin
                b_low = 1; b_tog = 0; b_gap = 0; b_gmin = 999; b_gmax = 0;
            end else begin
                b_low++;
                b_gap++;
                if (b.sclk != b_psclk) begin
                    b_tog++;
                    if (b_tog > 1) begin
                        if (b_gap < b_gmin) b_gmin = b_gap;
                        if (b_gap > b_gmax) b_gmax = b_gap;
                    end
                    b_gap = 0;
                end
            end
        end else if (!b_pcs) begin
            nb_pend--;
            chk("b_cs_low_cycles", b_low, 34);
            chk("b_sclk_toggles", b_tog, 32);
            chk("b_toggle_gap_min", b_gmin, 1);
            chk("b_toggle_gap_max", b_gmax, 1);
        end
        b_pcs   = b.cs_n;
        b_psclk = b.sclk;
    end

    task automatic step();
        @(posedge pclk);
        #2;
    endtask

    task automatic send_a(input logic [7:0] d, input logic pol,
                          input logic pha, input logic lsb,
                          input logic [7:0] cap, input logic [7:0] rx,
                          input logic hold, input logic abrt);
        int n;
        xf_t e;
        a.tx_data   = d;
        a.cpol      = pol;
        a.cpha      = pha;
        a.lsb_first = lsb;
        a.tx_valid  = 1'b1;
        n = 0;
        while (!a.tx_ready && n < 400) begin
            step();
            n++;
        end
        if (!a.tx_ready) begin
            nvec++;
            nfail++;
            $display("FAIL a_accept_timeout: got tx_ready=0, expected 1");
            a.tx_valid = 1'b0;
            return;
        end
        e.aborted = abrt;
        e.cap     = cap;
        e.cpol    = pol;
        xq_a.push_back(e);
        if (!abrt) rq_a.push_back(rx);
        step();
        if (!hold) a.tx_valid = 1'b0;
    endtask

    task automatic wait_a();
        int n;
        n = 0;
        while ((rq_a.size() != 0 || xq_a.size() != 0 || !a.tx_ready)
               && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            nvec++;
            nfail++;
            $display("FAIL a_done_timeout: got pending work, expected idle");
        end
    endtask

    task automatic send_b(input logic [15:0] d, input logic pol,
                          input logic pha, input logic lsb);
        int n;
        b.tx_data   = d;
        b.cpol      = pol;
        b.cpha      = pha;
        b.lsb_first = lsb;
        b.tx_valid  = 1'b1;
        n = 0;
        while (!b.tx_ready && n < 400) begin
            step();
            n++;
        end
        if (!b.tx_ready) begin
            nvec++;
            nfail++;
            $display("FAIL b_accept_timeout: got tx_ready=0, expected 1");
            b.tx_valid = 1'b0;
            return;
        end
        rq_b.push_back(d);
        nb_pend++;
        step();
        b.tx_valid = 1'b0;
        n = 0;
        while ((rq_b.size() != 0 || nb_pend != 0 || !b.tx_ready)
               && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            nvec++;
            nfail++;
            $display("FAIL b_done_timeout: got pending work, expected idle");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int acc0, nx0, n;
        a.tx_valid = 1'b0; a.tx_data = '0;
        a.cpol = 1'b0; a.cpha = 1'b0; a.lsb_first = 1'b0;
        b.tx_valid = 1'b0; b.tx_data = '0;
        b.cpol = 1'b0; b.cpha = 1'b0; b.lsb_first = 1'b0;

        // reset state
        step();
        step();
        chk("rst_cs_n", a.cs_n, 1);
        chk("rst_sclk", a.sclk, 0);
        chk("rst_mosi", a.mosi, 0);
        chk("rst_rx_valid", a.rx_valid, 0);
        chk("rst_rx_data", a.rx_data, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_tx_ready", a.tx_ready, 0);
        areset = 1'b0;
        step();
        chk("rst_release_tx_ready", a.tx_ready, 1);

        // mode 0, MSB first, loopback
        a_loop = 1'b1; bfm_cpha = 1'b0; bfm_lsb = 1'b0;
        send_a(8'hA5, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        wait_a();

        // mode 3, LSB first, slave returns 3C
        a_loop = 1'b0; bfm_cpha = 1'b1; bfm_lsb = 1'b1; bfm_ret = 8'h3C;
        send_a(8'h81, 1, 1, 1, 8'h81, 8'h3C, 0, 0);
        wait_a();
        chk("mode3_idle_sclk", a.sclk, 1);

        // inputs churn after accept; latched values must rule
        a_loop = 1'b1; bfm_cpha = 1'b1; bfm_lsb = 1'b0;
        send_a(8'h5A, 0, 1, 0, 8'h5A, 8'h5A, 0, 0);
        for (int i = 0; i < 24; i++) begin
            a.cpol      = ~a.cpol;
            a.cpha      = ~a.cpha;
            a.lsb_first = ~a.lsb_first;
            a.tx_data   = 8'($urandom);
            step();
        end
        a.cpol = 1'b0; a.cpha = 1'b0; a.lsb_first = 1'b0;
        wait_a();

        // tx_valid held across three words
        bfm_cpha = 1'b0;
        acc0 = a_acc;
        nx0  = a_nx;
        send_a(8'h01, 0, 0, 0, 8'h01, 8'h01, 1, 0);
        send_a(8'h02, 0, 0, 0, 8'h02, 8'h02, 1, 0);
        send_a(8'h03, 0, 0, 0, 8'h03, 8'h03, 0, 0);
        wait_a();
        chk("b2b_accepts", a_acc - acc0, 3);
        chk("b2b_cs_pulses", a_nx - nx0, 3);

        // reset at toggle 7 aborts the transfer
        send_a(8'hC3, 0, 0, 0, 8'hC3, 8'hC3, 0, 1);
        n = 0;
        while (a_tog < 7 && n < 200) begin
            step();
            n++;
        end
        chk("abort_reached_toggle7", (a_tog >= 7) ? 1 : 0, 1);
        areset = 1'b1;
        step();
        chk("abort_cs_n", a.cs_n, 1);
        chk("abort_tx_ready", a.tx_ready, 0);
        chk("abort_busy", a.busy, 0);
        areset = 1'b0;
        step();
        chk("abort_ready_after", a.tx_ready, 1);
        chk("abort_no_rx_valid", a.rx_valid, 0);

        // mode 2 transfer after the abort
        send_a(8'h96, 1, 0, 0, 8'h96, 8'h96, 0, 0);
        wait_a();

        // 16-bit, CLK_DIV=1 instance
        send_b(16'hBEEF, 0, 0, 0);
        send_b(16'h1234, 0, 1, 1);

        chk("a_ready_during_xfer", a_viol, 0);
        chk("a_queues_empty", xq_a.size() + rq_a.size(), 0);
        chk("b_queue_empty", rq_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
